// File: rtl/seq_detect_ctrl_if.sv
// seq_detect_ctrl_if: config, control and serial-stream signals of the sequence detector controller.
interface seq_detect_ctrl_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LW = $clog2(MAX_LEN) + 1;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_thresh;
    logic               start;
    logic               stop;
    logic               i;
    logic               out;
    logic [CNT_W-1:0]   match_cnt;
    logic               irq;
    logic               irq_ack;
    logic               busy;
    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_thresh, start, stop, i, irq_ack,
        input  cfg_ready, out, match_cnt, irq, busy
    );
    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_thresh, start, stop, i, irq_ack,
        output cfg_ready, out, match_cnt, irq, busy
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: runtime-configured bit-serial Mealy pattern detector with match counting and threshold irq.
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input logic             clk,
    input logic             rst,
    seq_detect_ctrl_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN) + 1;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d, mask, cand;
    logic [MAX_LEN-2:0] history_q, history_d;
    logic [LW-1:0]      len_q, len_d, fill_q, fill_d;
    logic               overlap_q, overlap_d, irq_q, irq_d, match;
    logic [CNT_W-1:0]   thresh_q, thresh_d, cnt_q, cnt_d, cnt_inc;
    always_comb begin
        for (int k = 0; k < MAX_LEN; k++) mask[k] = LW'(k) < len_q;
    end
    // candidate window: stored history plus the bit currently on i
    assign cand    = {history_q, bus.i};
    assign match   = state_q == RUN && fill_q >= len_q - 1'b1 && ((cand ^ pattern_q) & mask) == '0;
    assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        thresh_d  = thresh_q;
        history_d = history_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        irq_d     = irq_q;
        if (state_q == IDLE && bus.cfg_valid) begin
            pattern_d = bus.cfg_pattern;
            len_d     = bus.cfg_len == '0 ? LW'(1) : bus.cfg_len > LW'(MAX_LEN) ? LW'(MAX_LEN) : bus.cfg_len;
            overlap_d = bus.cfg_overlap;
            thresh_d  = bus.cfg_thresh;
        end
        case (state_q)
            IDLE: if (bus.start) begin
                state_d   = RUN;
                history_d = '0;
                fill_d    = '0;
                cnt_d     = '0;
            end
            RUN: begin
                history_d = cand[MAX_LEN-2:0];
                fill_d    = match && !overlap_q ? '0 : fill_q == len_q ? fill_q : fill_q + 1'b1;
                cnt_d     = match ? cnt_inc : cnt_q;
                if (bus.stop) begin
                    state_d = IDLE;
                    fill_d  = '0;
                end else if (match && thresh_q != '0 && cnt_inc == thresh_q) begin
                    state_d = HOLD;
                    irq_d   = 1'b1;
                end
            end
            HOLD: if (bus.stop) begin
                state_d = IDLE;
                irq_d   = 1'b0;
                fill_d  = '0;
            end else if (bus.irq_ack) begin
                state_d = RUN;
                irq_d   = 1'b0;
                cnt_d   = '0;
                fill_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            len_q     <= LW'(1);
            overlap_q <= 1'b1;
            thresh_q  <= '0;
            history_q <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            thresh_q  <= thresh_d;
            history_q <= history_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            irq_q     <= irq_d;
        end
    end
    assign bus.out       = match;
    assign bus.match_cnt = cnt_q;
    assign bus.irq       = irq_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.cfg_ready = state_q == IDLE;
endmodule
